password_lock: RTL and testbench

Consumes the debounced 10-bit switch word and debounced push-buttons, and implements the password-entry lock for the board. The user sets the switches and presses ENTER; the block compares the switch word against a stored password and unlocks, flags an error, or locks out after repeated failures. While unlocked, a SET press stores the current switch word as the new password. It sits downstream of the switch/button debouncers and drives LEDs directly.

---
 rtl/password_lock_if.sv | 23 ++
 rtl/password_lock.sv | 156 +++++++++++++++
 tb/tb_password_lock.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/password_lock_if.sv
// Signal bundle between the debouncers/LEDs and the password lock.
// Inputs are debounced levels sampled every clk; the lock edge-detects the buttons itself.
// There is no valid/ready: a button rising edge is the only "request", and outputs are registered status levels.
interface password_lock_if;
    logic [9:0] sw_clean;
    logic       btn_enter;
    logic       btn_set;
    logic       unlocked;
    logic       err;
    logic       alarm;
    logic [1:0] fail_count;
    logic [2:0] state_o;

    modport master (
        output sw_clean, btn_enter, btn_set,
        input  unlocked, err, alarm, fail_count, state_o
    );

    modport slave (
        input  sw_clean, btn_enter, btn_set,
        output unlocked, err, alarm, fail_count, state_o
    );
endinterface

// File: rtl/password_lock.sv
// Password-entry lock: compares the switch word on ENTER, unlocks, flags errors,
// locks out after repeated failures, and lets SET store a new password while open.
module password_lock #(
    parameter logic [9:0]  DEFAULT_PW   = 10'h2A5,
    parameter int unsigned MAX_ATTEMPTS = 3,
    parameter int unsigned ERR_CYCLES   = 25_000_000,
    parameter int unsigned OPEN_CYCLES  = 250_000_000,
    parameter int unsigned LOCK_CYCLES  = 500_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    password_lock_if.slave lock_if
);

    localparam int unsigned MAX_A   = (ERR_CYCLES > OPEN_CYCLES) ? ERR_CYCLES : OPEN_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > LOCK_CYCLES) ? MAX_A : LOCK_CYCLES;
    localparam int          TIMER_W = $clog2(MAX_CYC + 1);

    localparam logic [TIMER_W-1:0] ERR_LAST  = TIMER_W'(ERR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OPEN_LAST = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [2:0]         MAX_FAIL  = 3'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        S_LOCKED  = 3'd0,
        S_CHECK   = 3'd1,
        S_OPEN    = 3'd2,
        S_ERROR   = 3'd3,
        S_LOCKOUT = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [9:0]         pw_q, pw_d;
    logic [9:0]         attempt_q, attempt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         fail_q, fail_d;
    logic               enter_q, set_q;
    logic               unlocked_q, unlocked_d;
    logic               err_q, err_d;
    logic               alarm_q, alarm_d;

    logic               enter_pulse;
    logic               set_pulse;
    logic [2:0]         fail_inc;
    logic               timer_run;

    assign enter_pulse = lock_if.btn_enter & ~enter_q;
    assign set_pulse   = lock_if.btn_set & ~set_q;
    // Widened so the increment can never wrap before the lockout compare.
    assign fail_inc    = {1'b0, fail_q} + 3'd1;

    always_comb begin
        state_d   = state_q;
        pw_d      = pw_q;
        attempt_d = attempt_q;
        fail_d    = fail_q;
        timer_d   = timer_q;
        timer_run = 1'b0;

        case (state_q)
            S_LOCKED: begin
                if (enter_pulse) begin
                    attempt_d = lock_if.sw_clean;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (attempt_q == pw_q) begin
                    fail_d  = 2'd0;
                    state_d = S_OPEN;
                end else if (fail_inc >= MAX_FAIL) begin
                    fail_d  = MAX_FAIL[1:0];
                    state_d = S_LOCKOUT;
                end else begin
                    fail_d  = fail_inc[1:0];
                    state_d = S_ERROR;
                end
            end
            S_OPEN: begin
                // ENTER has priority over SET so a double press never changes the password.
                if (enter_pulse) begin
                    state_d = S_LOCKED;
                end else if (set_pulse) begin
                    pw_d    = lock_if.sw_clean;
                    timer_d = '0;
                end else if (timer_q == OPEN_LAST) begin
                    state_d = S_LOCKED;
                end else begin
                    timer_run = 1'b1;
                end
            end
            S_ERROR: begin
                if (timer_q == ERR_LAST) begin
                    state_d = S_LOCKED;
                end else begin
                    timer_run = 1'b1;
                end
            end
            S_LOCKOUT: begin
                if (timer_q == LOCK_LAST) begin
                    fail_d  = 2'd0;
                    state_d = S_LOCKED;
                end else begin
                    timer_run = 1'b1;
                end
            end
            default: begin
                state_d = S_LOCKED;
            end
        endcase

        // Every state entry starts the timer from zero.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_run) begin
            timer_d = timer_q + TIMER_W'(1);
        end

        unlocked_d = (state_d == S_OPEN);
        err_d      = (state_d == S_ERROR);
        alarm_d    = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOCKED;
            pw_q       <= DEFAULT_PW;
            attempt_q  <= '0;
            timer_q    <= '0;
            fail_q     <= 2'd0;
            enter_q    <= 1'b0;
            set_q      <= 1'b0;
            unlocked_q <= 1'b0;
            err_q      <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pw_q       <= pw_d;
            attempt_q  <= attempt_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            enter_q    <= lock_if.btn_enter;
            set_q      <= lock_if.btn_set;
            unlocked_q <= unlocked_d;
            err_q      <= err_d;
            alarm_q    <= alarm_d;
        end
    end

    assign lock_if.unlocked   = unlocked_q;
    assign lock_if.err        = err_q;
    assign lock_if.alarm      = alarm_q;
    assign lock_if.fail_count = fail_q;
    assign lock_if.state_o    = state_q;

endmodule

// File: tb/tb_password_lock.sv
// Bench for password_lock: scripted stimulus pushes the expected output word per
// cycle; a negedge monitor pops and compares it against the DUT.
module tb_password_lock;

    localparam int unsigned ERR_N  = 4;
    localparam int unsigned OPEN_N = 20;
    localparam int unsigned LOCK_N = 10;
    localparam int          W      = 8;

    logic clk;
    logic rst_n;

    password_lock_if lock_if ();

    password_lock #(
        .DEFAULT_PW  (10'h2A5),
        .MAX_ATTEMPTS(3),
        .ERR_CYCLES  (ERR_N),
        .OPEN_CYCLES (OPEN_N),
        .LOCK_CYCLES (LOCK_N)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .lock_if(lock_if.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    // Scoreboard
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] obs;

    assign obs = {lock_if.state_o, lock_if.unlocked, lock_if.err, lock_if.alarm, lock_if.fail_count};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [W-1:0] e;
            string        t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_val(t, 32'(obs), 32'(e));
        end
    end

    // Expected output word from the state code and fail count.
    function automatic logic [W-1:0] ob(input logic [2:0] s, input logic [1:0] fc);
        return {s, s == 3'd2, s == 3'd3, s == 3'd4, fc};
    endfunction

    // Driver tasks: inputs are set before the call, sampled at the next posedge.
    task automatic step(input logic [W-1:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        #1;
    endtask

    task automatic enter_ok(input logic [9:0] v, input logic [1:0] fc_before);
        lock_if.sw_clean  = v;
        lock_if.btn_enter = 1'b1;
        step(ob(3'd1, fc_before), "ok_check");
        lock_if.btn_enter = 1'b0;
        step(ob(3'd2, 2'd0), "ok_open");
    endtask

    task automatic enter_bad(input logic [9:0] v, input logic [1:0] fc_before);
        lock_if.sw_clean  = v;
        lock_if.btn_enter = 1'b1;
        step(ob(3'd1, fc_before), "bad_check");
        lock_if.btn_enter = 1'b0;
        for (int i = 0; i < ERR_N; i++) step(ob(3'd3, fc_before + 2'd1), "err_hold");
        step(ob(3'd0, fc_before + 2'd1), "err_exit");
    endtask

    initial begin
        logic [9:0] wrong;
        lock_if.sw_clean  = 10'h000;
        lock_if.btn_enter = 1'b0;
        lock_if.btn_set   = 1'b0;
        rst_n             = 1'b0;
        #23;
        check_val("reset_state", 32'(obs), 32'(0));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(ob(3'd0, 2'd0), "idle");

        // 1. correct entry then auto relock
        enter_ok(10'h2A5, 2'd0);
        for (int i = 0; i < OPEN_N - 1; i++) step(ob(3'd2, 2'd0), "open_hold");
        step(ob(3'd0, 2'd0), "open_timeout");

        // 2. two wrong entries
        enter_bad(10'h000, 2'd0);
        wrong = 10'($urandom_range(0, 1023));
        if (wrong == 10'h2A5) wrong = 10'h2A4;
        enter_bad(wrong, 2'd1);

        // 3. lockout, presses ignored, one held through the exit
        lock_if.sw_clean  = 10'h001;
        lock_if.btn_enter = 1'b1;
        step(ob(3'd1, 2'd2), "third_check");
        lock_if.btn_enter = 1'b0;
        step(ob(3'd4, 2'd3), "lockout_entry");
        lock_if.sw_clean = 10'h2A5;
        for (int i = 0; i < LOCK_N - 1; i++) begin
            lock_if.btn_enter = (i == 2 || i == 3 || i >= 6);
            step(ob(3'd4, 2'd3), "lockout_hold");
        end
        step(ob(3'd0, 2'd0), "lockout_exit");
        for (int i = 0; i < 3; i++) step(ob(3'd0, 2'd0), "held_no_pulse");
        lock_if.btn_enter = 1'b0;
        step(ob(3'd0, 2'd0), "release");

        // 4. password change restarts the open timer
        enter_ok(10'h2A5, 2'd0);
        for (int i = 0; i < 5; i++) step(ob(3'd2, 2'd0), "open_pre_set");
        lock_if.sw_clean = 10'h155;
        lock_if.btn_set  = 1'b1;
        step(ob(3'd2, 2'd0), "set_pw");
        lock_if.btn_set = 1'b0;
        for (int i = 0; i < 15; i++) step(ob(3'd2, 2'd0), "open_restart");
        lock_if.btn_enter = 1'b1;
        step(ob(3'd0, 2'd0), "manual_relock");
        lock_if.btn_enter = 1'b0;
        step(ob(3'd0, 2'd0), "idle");
        enter_bad(10'h2A5, 2'd0);
        enter_ok(10'h155, 2'd1);
        lock_if.btn_enter = 1'b1;
        step(ob(3'd0, 2'd0), "manual_relock");
        lock_if.btn_enter = 1'b0;
        step(ob(3'd0, 2'd0), "idle");

        // 5. held ENTER gives a single check; simultaneous ENTER+SET keeps password
        lock_if.sw_clean  = 10'h000;
        lock_if.btn_enter = 1'b1;
        step(ob(3'd1, 2'd0), "held_check");
        for (int i = 0; i < ERR_N; i++) step(ob(3'd3, 2'd1), "held_err");
        for (int i = 0; i < 50 - 1 - ERR_N; i++) step(ob(3'd0, 2'd1), "held_locked");
        lock_if.btn_enter = 1'b0;
        step(ob(3'd0, 2'd1), "release");
        enter_ok(10'h155, 2'd1);
        lock_if.sw_clean  = 10'h3FF;
        lock_if.btn_enter = 1'b1;
        lock_if.btn_set   = 1'b1;
        step(ob(3'd0, 2'd0), "enter_beats_set");
        lock_if.btn_enter = 1'b0;
        lock_if.btn_set   = 1'b0;
        step(ob(3'd0, 2'd0), "idle");
        enter_bad(10'h3FF, 2'd0);

        // 6. async reset mid-OPEN after a password change
        enter_ok(10'h155, 2'd1);
        lock_if.sw_clean = 10'h0F0;
        lock_if.btn_set  = 1'b1;
        step(ob(3'd2, 2'd0), "set_pw2");
        lock_if.btn_set = 1'b0;
        for (int i = 0; i < 3; i++) step(ob(3'd2, 2'd0), "open_hold2");
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset", 32'(obs), 32'(0));
        @(negedge clk);
        #1;
        check_val("reset_held", 32'(obs), 32'(0));
        rst_n = 1'b1;
        enter_bad(10'h0F0, 2'd0);
        enter_ok(10'h2A5, 2'd1);
        lock_if.btn_enter = 1'b1;
        step(ob(3'd0, 2'd0), "manual_relock");
        lock_if.btn_enter = 1'b0;
        step(ob(3'd0, 2'd0), "idle");

        check_val("queue_drain", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
